// File: rtl/twos_to_signmag.sv
// rtl/twos_to_signmag.sv - bit-serial two's-complement to sign/magnitude converter
// Resolves one magnitude bit per clock LSB first, behind a valid/ready handshake.
module twos_to_signmag #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] din,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         sign,
    output logic [N-1:0] mag,
    output logic         zero,
    output logic         min_neg
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  d;
    logic [CW-1:0] cnt;
    logic          carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = BUSY;
            BUSY:    if (cnt == LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Negative operands are negated as ~d + 1, rippling the +1 through carry one bit per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d       <= '0;
            cnt     <= '0;
            carry   <= 1'b1;
            sign    <= 1'b0;
            mag     <= '0;
            zero    <= 1'b0;
            min_neg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d     <= din;
                        sign  <= din[N-1];
                        mag   <= '0;
                        cnt   <= '0;
                        carry <= 1'b1;
                    end
                end
                BUSY: begin
                    if (sign) begin
                        mag[cnt] <= ~d[cnt] ^ carry;
                        carry    <= ~d[cnt] & carry;
                    end else begin
                        mag[cnt] <= d[cnt];
                    end
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        zero    <= (d == '0);
                        min_neg <= (d == MOST_NEG);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_twos_to_signmag.sv
// tb/tb_twos_to_signmag.sv - scoreboard bench for twos_to_signmag at N=8
module tb_twos_to_signmag;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] din = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         sign;
    logic [N-1:0] mag;
    logic         zero;
    logic         min_neg;

    typedef struct packed {
        logic         s;
        logic [N-1:0] m;
        logic         z;
        logic         mn;
    } res_t;

    res_t got;
    res_t q[$];
    int   checks = 0;
    int   errors = 0;

    assign got = {sign, mag, zero, min_neg};

    twos_to_signmag #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .out_valid(out_valid), .out_ready(out_ready), .sign(sign), .mag(mag),
        .zero(zero), .min_neg(min_neg)
    );

    always #5 clk = ~clk;

    function automatic res_t ref_model(input logic [N-1:0] v);
        res_t r;
        int   sv;
        sv   = int'($signed(v));
        r.s  = (sv < 0);
        r.m  = N'((sv < 0) ? -sv : sv);
        r.z  = (sv == 0);
        r.mn = (sv == -(1 << (N - 1)));
        return r;
    endfunction

    // Presents v for one edge from an IDLE negedge; returns on the negedge after acceptance.
    task automatic accept(input logic [N-1:0] v);
        din      = v;
        in_valid = 1'b1;
        q.push_back(ref_model(v));
        @(negedge clk);
        in_valid = 1'b0;
        din      = N'($urandom);
    endtask

    task automatic wait_done(output int edges);
        edges = 1;
        while (!out_valid && edges < 40) begin
            @(negedge clk);
            din = N'($urandom);
            edges++;
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || got !== res_t'(0)) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b res=%h expected 1 0 0", in_ready, out_valid, got);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sign_cases;
        logic [N-1:0] vals [4];
        res_t         e;
        int           edges;
        vals = '{8'hF6, 8'h05, 8'h80, 8'h00};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            accept(vals[i]);
            wait_done(edges);
            checks++;
            if (edges !== N + 1) begin
                errors++;
                $display("FAIL latency_%h: got %0d edges expected %0d", vals[i], edges, N + 1);
            end
            e = q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL result_%h: got %h expected %h", vals[i], got, e);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || got !== e) begin
                errors++;
                $display("FAIL retain_%h: out_valid=%b in_ready=%b res=%h expected 0 1 %h", vals[i], out_valid, in_ready, got, e);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_hold;
        res_t e;
        int   edges;
        int   bad;
        accept(8'hFF);
        wait_done(edges);
        e = q.pop_front();
        checks++;
        if (e !== {1'b1, 8'h01, 1'b0, 1'b0} || edges !== N + 1) begin
            errors++;
            $display("FAIL hold_setup: model %h edges %0d expected 101 and %0d", e, edges, N + 1);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got !== e || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_stable_%0d: res=%h in_ready=%b out_valid=%b expected %h 0 1", i, got, in_ready, out_valid, e);
            end
            in_valid = (i == 2);
            din      = 8'h33;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < N + 4; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || got !== e) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_no_queue: %0d bad idle cycles expected 0", bad);
        end
    endtask

    task automatic test_abort;
        res_t e;
        int   edges;
        out_ready = 1'b1;
        accept(8'h7F);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || got !== res_t'(0)) begin
            errors++;
            $display("FAIL abort_async: in_ready=%b out_valid=%b res=%h expected 1 0 0", in_ready, out_valid, got);
        end
        #1 rst = 1'b0;
        void'(q.pop_back());
        @(negedge clk);
        accept(8'hFE);
        wait_done(edges);
        e = q.pop_front();
        checks++;
        if (got !== {1'b1, 8'h02, 1'b0, 1'b0} || got !== e || edges !== N + 1) begin
            errors++;
            $display("FAIL abort_recover: got %h after %0d edges expected 102 after %0d", got, edges, N + 1);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [N-1:0] vals [4];
        int           acc_t [4];
        int           nsent = 0;
        int           ndone = 0;
        res_t         e;
        vals = '{8'h81, 8'h7E, 8'hC0, 8'h01};
        out_ready = 1'b1;
        for (int t = 0; t < 80 && ndone < 4; t++) begin
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: result %h with empty scoreboard", got);
                end else begin
                    e = q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL b2b_result_%0d: got %h expected %h", ndone, got, e);
                    end
                end
                ndone++;
            end
            if (in_ready) begin
                if (nsent < 4) begin
                    din      = vals[nsent];
                    in_valid = 1'b1;
                    q.push_back(ref_model(vals[nsent]));
                    acc_t[nsent] = t;
                    nsent++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (ndone != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d results expected 4", ndone);
        end
        for (int k = 1; k < nsent; k++) begin
            checks++;
            if (acc_t[k] - acc_t[k-1] != N + 2) begin
                errors++;
                $display("FAIL b2b_spacing_%0d: got %0d cycles expected %0d", k, acc_t[k] - acc_t[k-1], N + 2);
            end
        end
    endtask

    task automatic test_exhaustive;
        res_t e;
        int   edges;
        int   pushed = 0;
        int   popped = 0;
        for (int v = 0; v < 256; v++) begin
            accept(N'(v));
            pushed++;
            wait_done(edges);
            checks++;
            if (edges !== N + 1) begin
                errors++;
                $display("FAIL exh_latency_%02h: got %0d edges expected %0d", v, edges, N + 1);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks++;
            if (q.size() == 0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL exh_deliver_%02h: out_valid=%b queue=%0d expected 1 and nonempty", v, out_valid, q.size());
            end else begin
                e = q.pop_front();
                popped++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL exh_result_%02h: got %h expected %h", v, got, e);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL exh_once_%02h: out_valid=%b in_ready=%b expected 0 1", v, out_valid, in_ready);
            end
        end
        checks++;
        if (q.size() != 0 || popped != pushed) begin
            errors++;
            $display("FAIL exh_accounting: popped %0d of %0d, %0d left expected all and 0", popped, pushed, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_sign_cases();
        test_hold();
        test_abort();
        test_back_to_back();
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/twos_to_signmag.md
TWOS_TO_SIGNMAG -- requirements
Module: twos_to_signmag

Interface
REQ-001 SHALL have parameter N, default 8, giving the two's-complement input width and the magnitude output width (N >= 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, meaning din is presented.
REQ-005 SHALL have port in_ready, output, 1, meaning the block can accept din.
REQ-006 SHALL have port din, input, N, the two's-complement operand (e.g. an exponent difference).
REQ-007 SHALL have port out_valid, output, 1, meaning the result is available.
REQ-008 SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-009 SHALL have port sign, output, 1, the sign bit of the result (1 = negative).
REQ-010 SHALL have port mag, output, N, the unsigned magnitude |din|.
REQ-011 SHALL have port zero, output, 1, asserted when din was 0.
REQ-012 SHALL have port min_neg, output, 1, asserted when din was 1 followed by N-1 zeros (the most negative value).

Function
REQ-013 SHALL implement a three-state FSM: IDLE, BUSY and DONE.
REQ-014 in_ready SHALL equal (state == IDLE) and nothing else.
REQ-015 out_valid SHALL equal (state == DONE) and nothing else.
REQ-016 Acceptance SHALL occur on a rising edge with in_valid=1 in IDLE; on that edge the block latches din, sets sign=din[N-1], clears mag, sets bit counter=0 and carry=1, and goes to BUSY.
REQ-017 When in_valid=0 in IDLE, the FSM and all outputs SHALL hold.
REQ-018 In BUSY, each edge SHALL resolve exactly one bit i=counter, LSB first:
- if sign=1: mag[i] = ~d[i] XOR carry and carry = ~d[i] AND carry;
- if sign=0: mag[i] = d[i].
REQ-019 The BUSY edge with counter=N-1 SHALL set state=DONE and register zero and min_neg from the latched operand.
REQ-020 Latency SHALL be fixed: out_valid rises exactly N+1 rising edges after the acceptance edge, counting the acceptance edge; the sign of din has no effect on latency.
REQ-021 In DONE, sign, mag, zero and min_neg SHALL hold stable until handshake completion on an edge with out_ready=1, whereupon state=IDLE.
REQ-022 Outputs SHALL retain the last result in IDLE until the next acceptance.
REQ-023 Back-to-back throughput SHALL be one operand per N+2 cycles when out_ready is tied high; there SHALL be no combinational path from out_ready to in_ready.
REQ-024 The most negative input SHALL yield sign=1, mag = 1 followed by N-1 zeros (representable unsigned), and min_neg=1; no overflow or error condition exists.
REQ-025 For din=0: sign=0, mag=0, zero=1; the final carry-out SHALL be discarded.
REQ-026 din SHALL be sampled only on the acceptance edge; changes during BUSY or DONE SHALL be ignored.
REQ-027 in_valid asserted outside IDLE SHALL be ignored; no queuing occurs.

Reset
REQ-028 While rst=1, the block SHALL immediately, without waiting for clk, force state=IDLE, counter=0, carry=1, sign=0, mag=0, zero=0, min_neg=0, in_ready=1 and out_valid=0.
REQ-029 Reset asserted in BUSY or DONE SHALL abort the operation with no output produced.
REQ-030 After rst deasserts, the first edge with in_valid=1 SHALL be a valid acceptance.

Verification (N=8)
REQ-031 Bench SHALL cover: din=8'hF6 (-10), out_ready=1 -> 9 edges later out_valid=1, sign=1, mag=8'h0A, zero=0, min_neg=0.
REQ-032 Bench SHALL cover: din=8'h05 -> sign=0, mag=8'h05, with the same 9-edge latency as the negative case.
REQ-033 Bench SHALL cover: din=8'h80 -> sign=1, mag=8'h80, min_neg=1; then din=8'h00 -> sign=0, mag=8'h00, zero=1.
REQ-034 Bench SHALL cover: result for din=8'hFF held with out_ready=0 for 5 cycles -> sign=1 and mag=8'h01 stable, in_ready=0 throughout, and a second in_valid pulse is ignored.
REQ-035 Bench SHALL cover: rst pulsed between edges while counter=3 -> in_ready=1 and out_valid=0 immediately; a next din=8'hFE yields sign=1, mag=8'h02.
REQ-036 Bench SHALL cover: exhaustive din 0..255 with random out_ready -> sign/mag match a reference model and every result is delivered exactly once.
